// File: rtl/console_rx_fifo_if.sv
// rtl/console_rx_fifo_if.sv - UART poll side and CPU pop side signals of the console receive FIFO
interface console_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [31:0]         uart_dat_do;
  logic                uart_dat_re;
  logic                pop;
  logic [7:0]          rd_data;
  logic                rd_valid;
  logic                full;
  logic [DEPTH_LOG2:0] count;

  modport master (
    output uart_dat_do, pop,
    input  uart_dat_re, rd_data, rd_valid, full, count
  );

  modport slave (
    input  uart_dat_do, pop,
    output uart_dat_re, rd_data, rd_valid, full, count
  );
endinterface

// File: rtl/console_rx_fifo.sv
// rtl/console_rx_fifo.sv - polls the console UART, acknowledges bytes and buffers them in a FWFT FIFO
module console_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic               clk,
  input  logic               resetn,
  console_rx_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {POLL, ACK, SETTLE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  byte_pending;
  logic                  is_full;
  logic                  push;
  logic                  pop_ok;

  assign byte_pending = bus.uart_dat_do != 32'hFFFF_FFFF;
  assign is_full      = cnt == CNT_FULL;
  // Eligibility uses the registered count, so a same-cycle pop never makes room.
  assign pop_ok       = bus.pop && (cnt != '0);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      POLL: begin
        if (byte_pending && !is_full) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = SETTLE;
      SETTLE:  state_d = POLL;
      default: state_d = POLL;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= POLL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately left out of reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.uart_dat_do[7:0];
  end

  assign bus.uart_dat_re = state_q == ACK;
  assign bus.rd_data     = mem[rd_ptr];
  assign bus.rd_valid    = cnt != '0;
  assign bus.full        = is_full;
  assign bus.count       = cnt;
endmodule

// File: tb/tb_console_rx_fifo.sv
// tb/tb_console_rx_fifo.sv - self-checking bench for console_rx_fifo
module tb_console_rx_fifo;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk;
  logic resetn;

  console_rx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  console_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int re_pulses = 0;

  logic [7:0] src[$];
  logic [7:0] mq[$];
  int         busy;

  typedef struct {
    int         nbytes;
    int         npops;
    int         exp_count;
    logic       exp_full;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vecs[6];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_outputs();
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("rd_valid", 32'(bus.rd_valid), 32'(mq.size() != 0));
    chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    chk("uart_dat_re", 32'(bus.uart_dat_re), 32'(busy == 2));
    if (mq.size() != 0) chk("rd_data", 32'(bus.rd_data), 32'(mq[0]));
  endfunction

  task automatic step(input logic p);
    logic        cap, pop_ok, re_s;
    logic [31:0] d;
    check_outputs();
    d = (src.size() != 0) ? {24'h0, src[0]} : 32'hFFFF_FFFF;
    bus.uart_dat_do = d;
    bus.pop = p;
    re_s   = bus.uart_dat_re;
    cap    = (busy == 0) && (d != 32'hFFFF_FFFF) && (mq.size() < DEPTH);
    pop_ok = p && (mq.size() != 0);
    @(posedge clk);
    if (pop_ok) void'(mq.pop_front());
    if (cap) mq.push_back(d[7:0]);
    busy = cap ? 2 : (busy > 0 ? busy - 1 : 0);
    if (re_s) re_pulses++;
    if (re_s && src.size() != 0) void'(src.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.pop = 1'b0;
    bus.uart_dat_do = 32'hFFFF_FFFF;
    src.delete();
    mq.delete();
    busy = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  int pop_pct;

  initial begin
    vecs[0] = '{nbytes: 0,  npops: 0,  exp_count: 0,  exp_full: 1'b0, exp_head: 8'h00};
    vecs[1] = '{nbytes: 1,  npops: 0,  exp_count: 1,  exp_full: 1'b0, exp_head: 8'h00};
    vecs[2] = '{nbytes: 3,  npops: 1,  exp_count: 2,  exp_full: 1'b0, exp_head: 8'h01};
    vecs[3] = '{nbytes: 16, npops: 0,  exp_count: 16, exp_full: 1'b1, exp_head: 8'h00};
    vecs[4] = '{nbytes: 20, npops: 4,  exp_count: 16, exp_full: 1'b1, exp_head: 8'h04};
    vecs[5] = '{nbytes: 18, npops: 18, exp_count: 0,  exp_full: 1'b0, exp_head: 8'h00};

    resetn = 1'b0;
    bus.pop = 1'b0;
    bus.uart_dat_do = 32'hFFFF_FFFF;
    busy = 0;
    repeat (2) @(negedge clk);
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset_full", 32'(bus.full), 32'd0);
    chk("reset_re", 32'(bus.uart_dat_re), 32'd0);
    resetn = 1'b1;

    // Idle UART: no strobe, nothing buffered.
    re_pulses = 0;
    repeat (20) step(1'b0);
    chk("idle_re_pulses", 32'(re_pulses), 32'd0);
    chk("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("idle_count", 32'(bus.count), 32'd0);

    // Single byte 0x41.
    re_pulses = 0;
    src.push_back(8'h41);
    repeat (10) step(1'b0);
    chk("single_re_pulses", 32'(re_pulses), 32'd1);
    chk("single_rd_data", 32'(bus.rd_data), 32'h41);
    chk("single_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("single_count", 32'(bus.count), 32'd1);
    step(1'b1);
    chk("single_pop_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("single_pop_count", 32'(bus.count), 32'd0);

    // Fill to full, 17th byte held back, pop frees one slot.
    do_reset();
    for (int i = 0; i <= 16; i++) src.push_back(8'(i));
    repeat (60) step(1'b0);
    chk("fill_count", 32'(bus.count), 32'd16);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_held", 32'(src.size()), 32'd1);
    chk("fill_head", 32'(bus.rd_data), 32'h00);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("refill_count", 32'(bus.count), 32'd16);
    chk("refill_src_empty", 32'(src.size()), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", 32'(bus.rd_data), 32'(i));
      step(1'b1);
    end
    chk("drain_rd_valid", 32'(bus.rd_valid), 32'd0);

    // Push and pop in the same cycle at count 5.
    do_reset();
    for (int i = 0; i < 5; i++) src.push_back(8'(8'h10 + i));
    repeat (25) step(1'b0);
    chk("pp_pre_count", 32'(bus.count), 32'd5);
    src.push_back(8'h55);
    step(1'b1);
    chk("pp_count", 32'(bus.count), 32'd5);
    chk("pp_head", 32'(bus.rd_data), 32'h11);
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("pp_tail", 32'(bus.rd_data), 32'h55);

    // Asynchronous reset while in ACK with count 3.
    do_reset();
    src.push_back(8'hA0);
    src.push_back(8'hA1);
    repeat (10) step(1'b0);
    src.push_back(8'h77);
    step(1'b0);
    chk("ack_re", 32'(bus.uart_dat_re), 32'd1);
    chk("ack_count", 32'(bus.count), 32'd3);
    #2 resetn = 1'b0;
    #1;
    chk("async_re", 32'(bus.uart_dat_re), 32'd0);
    chk("async_count", 32'(bus.count), 32'd0);
    chk("async_rd_valid", 32'(bus.rd_valid), 32'd0);
    mq.delete();
    src.delete();
    busy = 0;
    bus.uart_dat_do = 32'hFFFF_FFFF;
    @(negedge clk);
    resetn = 1'b1;
    src.push_back(8'hC3);
    step(1'b0);
    chk("resume_count", 32'(bus.count), 32'd1);
    chk("resume_data", 32'(bus.rd_data), 32'hC3);

    // Table of fill/pop scenarios.
    foreach (vecs[v]) begin
      do_reset();
      for (int i = 0; i < vecs[v].nbytes; i++) src.push_back(8'(i));
      repeat (3 * vecs[v].nbytes + 6) step(1'b0);
      for (int i = 0; i < vecs[v].npops; i++) begin
        step(1'b1);
        repeat (3) step(1'b0);
      end
      repeat (4) step(1'b0);
      chk("vec_count", 32'(bus.count), 32'(vecs[v].exp_count));
      chk("vec_full", 32'(bus.full), 32'(vecs[v].exp_full));
      if (vecs[v].exp_count != 0)
        chk("vec_head", 32'(bus.rd_data), 32'(vecs[v].exp_head));
    end

    // Randomized traffic against the queue model.
    do_reset();
    pop_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) pop_pct = (c / 500 % 3 == 0) ? 10 : ((c / 500 % 3 == 1) ? 90 : 50);
      if (src.size() < 4 && $urandom_range(0, 2) == 0) src.push_back(8'($urandom));
      step(logic'($urandom_range(0, 99) < pop_pct));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
